// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Round-robin arbiter that shares one APB master port between two
//   requesters. Each granted transfer goes through IDLE -> SETUP -> ACCESS.
//   The slave select comes from the top address bit. A transfer whose
//   ACCESS phase waits TIMEOUT cycles without Pready is aborted and
//   reported with err.
//
// Ports
//   Pclk, Prst                 clock, synchronous active-high reset
//   reqN/addrN/writeN/wdataN   requester N transfer (N = 0, 1); req held until done[N]
//   gnt[1:0]                   one-hot owner, high from SETUP through ACCESS
//   done[1:0]                  one-cycle completion pulse per requester
//   err                        high with done when the transfer was aborted
//   rdata                      read data of the last successful read
//   Paddr/Pwrite/Pwdata        APB request, stable from SETUP through ACCESS
//   Psel1/Psel2/Penable        APB select (Paddr[AW-1]: 0 -> slave1, 1 -> slave2), access phase
//   Pready/Prdata              muxed slave response, only sampled in ACCESS
module apb_master_arbiter #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          Pclk,
    input  logic          Prst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          write0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          write1,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] Paddr,
    output logic          Pwrite,
    output logic [DW-1:0] Pwdata,
    output logic          Psel1,
    output logic          Psel2,
    output logic          Penable,
    input  logic          Pready,
    input  logic [DW-1:0] Prdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The abort fires on the edge where the wait count would reach TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic            lp_q, lp_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            elig0, elig1, pick1;

    // A requester that just got its done pulse is ignored for that cycle,
    // so a held req only re-arbitrates one cycle later as a new request.
    assign elig0 = req0 & ~done_q[0];
    assign elig1 = req1 & ~done_q[1];
    // Requester 1 wins when it is alone, or on a tie when 0 was granted last.
    assign pick1 = elig1 & (~elig0 | ~lp_q);

    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            lp_q     <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            lp_q     <= lp_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        lp_d     = lp_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (elig0 | elig1) begin
                    paddr_d  = pick1 ? addr1  : addr0;
                    pwrite_d = pick1 ? write1 : write0;
                    pwdata_d = pick1 ? wdata1 : wdata0;
                    gnt_d    = pick1 ? 2'b10  : 2'b01;
                    lp_d     = pick1;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (Pready) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    if (!pwrite_q) begin
                        rdata_d = Prdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign Paddr   = paddr_q;
    assign Pwrite  = pwrite_q;
    assign Pwdata  = pwdata_q;
    assign Psel1   = (state_q != IDLE) & ~paddr_q[AW-1];
    assign Psel2   = (state_q != IDLE) &  paddr_q[AW-1];
    assign Penable = (state_q == ACCESS);

endmodule
